// File: rtl/fixed_to_float_pipe.sv
// -----------------------------------------------------------------------------
// fixed_to_float_pipe
//   Four-stage pipelined converter from signed two's-complement fixed point
//   (DATA_WIDTH_fix bits, FRAC_BITS fractional) to IEEE-754 single precision.
//   Valid/ready handshake on both sides. The whole pipe advances together
//   whenever the output register is empty or being drained.
//
//   Stages:
//     S1  sign capture and absolute value
//     S2  leading-one position and zero detect
//     S3  left-normalise, biased exponent
//     S4  mantissa rounding and packing (output register)
//
//   Build option:
//     FIX2FLT_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                               undefined -> truncate toward zero
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     fix_in     fixed-point operand
//     in_valid   fix_in valid
//     in_ready   block accepts fix_in this cycle
//     float_out  converted single-precision result
//     out_valid  float_out valid
//     out_ready  downstream accepts float_out
// -----------------------------------------------------------------------------
module fixed_to_float_pipe #(
    parameter int DATA_WIDTH_fix   = 64,
    parameter int DATA_WIDTH_float = 32,
    parameter int FRAC_BITS        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH_fix-1:0]   fix_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH_float-1:0] float_out,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int DW = DATA_WIDTH_fix;
    // Width of the bits below the leading one after normalisation.
    localparam int FW = DW - 1;
    localparam int PW = $clog2(DW);
    // Biased exponent = p - FRAC_BITS + 127. The true value always lies in
    // 1..254 for legal parameters, so modulo-256 arithmetic is exact.
    localparam logic [7:0] EXP_ADJ = 8'(127 - FRAC_BITS);

    logic          w_adv;

    logic          r_s1_valid;
    logic          r_s1_sign;
    logic [DW-1:0] r_s1_mag;

    logic          r_s2_valid;
    logic          r_s2_sign;
    logic          r_s2_zero;
    logic [PW-1:0] r_s2_p;
    logic [FW-1:0] r_s2_mag;

    logic          r_s3_valid;
    logic          r_s3_sign;
    logic [7:0]    r_s3_exp;
    logic [22:0]   r_s3_mant;
`ifdef FIX2FLT_ROUND_NEAREST_EN
    logic          r_s3_guard;
    logic          r_s3_sticky;
`endif

    logic          r_out_valid;
    logic [31:0]   r_float_out;

    logic [PW-1:0] w_p;
    logic          w_zero;
    logic [PW-1:0] w_sh;
    logic [7:0]    w_exp;

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign float_out = r_float_out;

    // ------------------------------------------------------------------ S1
    // Unary minus of the most negative value yields 2^(DW-1), which is the
    // correct magnitude when read as unsigned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= fix_in[DW-1];
            r_s1_mag   <= fix_in[DW-1] ? -fix_in : fix_in;
        end
    end

    // ------------------------------------------------------------------ S2
    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < DW; i++) begin
            if (r_s1_mag[i]) begin
                w_p = PW'(i);
            end
        end
    end

    assign w_zero = (r_s1_mag == '0);

    // The leading one itself is implicit in the float format, so only the
    // bits below the MSB are carried forward; for the most negative input
    // the MSB is the leading one and drops out naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_p     <= '0;
            r_s2_mag   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_zero  <= w_zero;
            r_s2_p     <= w_p;
            r_s2_mag   <= r_s1_mag[FW-1:0];
        end
    end

    // ------------------------------------------------------------------ S3
    // Shifting by DW-1-p pushes the leading one just past the top of the
    // FW-bit field, leaving the fraction bits left-aligned.
    assign w_sh  = PW'(DW - 1) - r_s2_p;
    assign w_exp = r_s2_zero ? 8'd0 : (8'(r_s2_p) + EXP_ADJ);

`ifdef FIX2FLT_ROUND_NEAREST_EN
    logic [FW-1:0] w_frac;
    assign w_frac = r_s2_mag << w_sh;
`else
    logic [22:0]   w_mant;
    assign w_mant = 23'((r_s2_mag << w_sh) >> (FW - 23));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid  <= 1'b0;
            r_s3_sign   <= 1'b0;
            r_s3_exp    <= '0;
            r_s3_mant   <= '0;
`ifdef FIX2FLT_ROUND_NEAREST_EN
            r_s3_guard  <= 1'b0;
            r_s3_sticky <= 1'b0;
`endif
        end else if (w_adv) begin
            r_s3_valid  <= r_s2_valid;
            // Zero always packs as +0.
            r_s3_sign   <= r_s2_sign && !r_s2_zero;
            r_s3_exp    <= w_exp;
`ifdef FIX2FLT_ROUND_NEAREST_EN
            r_s3_mant   <= w_frac[FW-1 -: 23];
            r_s3_guard  <= w_frac[FW-24];
            r_s3_sticky <= |w_frac[FW-25:0];
`else
            r_s3_mant   <= w_mant;
`endif
        end
    end

    // ------------------------------------------------------------------ S4
`ifdef FIX2FLT_ROUND_NEAREST_EN
    logic        w_round_up;
    logic [30:0] w_rounded;
    assign w_round_up = r_s3_guard && (r_s3_sticky || r_s3_mant[0]);
    // Adding across {exp, mant} lets a mantissa overflow clear the mantissa
    // and bump the exponent in one step.
    assign w_rounded  = {r_s3_exp, r_s3_mant} + 31'(w_round_up);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_float_out <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s3_valid;
`ifdef FIX2FLT_ROUND_NEAREST_EN
            r_float_out <= {r_s3_sign, w_rounded};
`else
            r_float_out <= {r_s3_sign, r_s3_exp, r_s3_mant};
`endif
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// -----------------------------------------------------------------------------
// tb_fixed_to_float_pipe
//   Directed bench for fixed_to_float_pipe (DATA_WIDTH_fix=64, FRAC_BITS=32).
//   Expected results are hand-computed constants; rounding-sensitive values
//   switch with FIX2FLT_ROUND_NEAREST_EN.
// -----------------------------------------------------------------------------
module tb_fixed_to_float_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] fix_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] float_out;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FIX2FLT_ROUND_NEAREST_EN
    localparam logic [31:0] EXP_TIE_ODD = 32'h4B800002;
    localparam logic [31:0] EXP_CARRY   = 32'h4C000000;
    localparam logic [31:0] EXP_GS      = 32'h4B800001;
    localparam logic [31:0] EXP_NEG_TIE = 32'hCB800002;
    localparam logic [31:0] EXP_MAXPOS  = 32'h4F000000;
`else
    localparam logic [31:0] EXP_TIE_ODD = 32'h4B800001;
    localparam logic [31:0] EXP_CARRY   = 32'h4BFFFFFF;
    localparam logic [31:0] EXP_GS      = 32'h4B800000;
    localparam logic [31:0] EXP_NEG_TIE = 32'hCB800001;
    localparam logic [31:0] EXP_MAXPOS  = 32'h4EFFFFFF;
`endif

    fixed_to_float_pipe #(
        .DATA_WIDTH_fix  (64),
        .DATA_WIDTH_float(32),
        .FRAC_BITS       (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fix_in   (fix_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .float_out(float_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sends one value into an empty pipe and reports the result and the
    // number of cycles until out_valid (0 if it never appeared).
    task automatic convert_single(input logic [63:0] v, output logic [31:0] got,
                                  output int lat);
        @(negedge clk);
        fix_in    = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        fix_in   = '0;
        lat = 0;
        got = '0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            if (out_valid) begin
                lat = n;
                got = float_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        fix_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_out_valid: got %b want 0", out_valid);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (float_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_float_out: got %h want 00000000", float_out);
        end
    endtask

    task automatic test_basic();
        logic [63:0] vin  [3] = '{64'h00000001_00000000, 64'hFFFFFFFD_00000000,
                                  64'h00000000_80000000};
        logic [31:0] vexp [3] = '{32'h3F800000, 32'hC0400000, 32'h3F000000};
        logic [31:0] got;
        int          lat;
        for (int k = 0; k < 3; k++) begin
            convert_single(vin[k], got, lat);
            n_checks++;
            if (got !== vexp[k]) begin
                n_fail++;
                $display("FAIL basic_value[%0d]: got %h want %h", k, got, vexp[k]);
            end
            n_checks++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d want 4", k, lat);
            end
        end
    endtask

    task automatic test_edges();
        logic [63:0] vin  [4] = '{64'h0, 64'h80000000_00000000,
                                  64'h00000000_00000001, 64'h7FFFFFFF_FFFFFFFF};
        logic [31:0] vexp [4];
        logic [31:0] got;
        int          lat;
        vexp = '{32'h00000000, 32'hCF000000, 32'h2F800000, EXP_MAXPOS};
        for (int k = 0; k < 4; k++) begin
            convert_single(vin[k], got, lat);
            n_checks++;
            if (got !== vexp[k] || lat != 4) begin
                n_fail++;
                $display("FAIL edge_value[%0d]: got %h lat %0d want %h lat 4",
                         k, got, lat, vexp[k]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [63:0] vin  [5] = '{64'h01000003_00000000, 64'h01FFFFFF_00000000,
                                  64'h01000001_80000000, 64'h01000001_00000000,
                                  64'hFEFFFFFD_00000000};
        logic [31:0] vexp [5];
        logic [31:0] got;
        int          lat;
        vexp = '{EXP_TIE_ODD, EXP_CARRY, EXP_GS, 32'h4B800000, EXP_NEG_TIE};
        for (int k = 0; k < 5; k++) begin
            convert_single(vin[k], got, lat);
            n_checks++;
            if (got !== vexp[k]) begin
                n_fail++;
                $display("FAIL round_value[%0d]: got %h want %h", k, got, vexp[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vexp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                  32'h40800000, 32'h40A00000, 32'h40C00000,
                                  32'h40E00000, 32'h41000000};
        int          sent = 0;
        int          recv = 0;
        int          stall_cycles = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_val = '0;
        for (int c = 0; c < 80 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 9);
            in_valid  = (sent < 8);
            fix_in    = (sent < 8) ? {32'(sent + 1), 32'h0} : 64'h0;
            #1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || float_out !== prev_val) begin
                    n_fail++;
                    $display("FAIL bp_hold: got valid %b data %h want valid 1 data %h",
                             out_valid, float_out, prev_val);
                end
            end
            if (out_valid && !out_ready) begin
                stall_cycles++;
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: got %b want 0 at cycle %0d", in_ready, c);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (float_out !== vexp[recv]) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got %h want %h", recv, float_out, vexp[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_val   = float_out;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv != 8) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results want 8", recv);
        end
        n_checks++;
        if (stall_cycles == 0) begin
            n_fail++;
            $display("FAIL bp_stall_seen: got 0 stall cycles want at least 1");
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_duplicate: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vin [12] = '{64'h00000001_00000000, 64'hFFFFFFFD_00000000,
                                  64'h00000000_80000000, 64'h0,
                                  64'h80000000_00000000, 64'h00000000_00000001,
                                  64'hFFFFFFFF_00000000, 64'h7FFFFFFF_FFFFFFFF,
                                  64'h01000003_00000000, 64'hFFFFFFFF_80000000,
                                  64'h00000000_00000003, 64'h01FFFFFF_00000000};
        logic [31:0] vexp [12];
        int sent = 0;
        int recv = 0;
        vexp = '{32'h3F800000, 32'hC0400000, 32'h3F000000, 32'h00000000,
                 32'hCF000000, 32'h2F800000, 32'hBF800000, EXP_MAXPOS,
                 EXP_TIE_ODD,  32'hBF000000, 32'h30400000, EXP_CARRY};
        for (int c = 0; c < 200 && recv < 12; c++) begin
            @(negedge clk);
            out_ready = (c % 3) != 2;
            in_valid  = (sent < 12) && ((c % 5) != 3);
            fix_in    = (sent < 12) ? vin[sent] : 64'h0;
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (float_out !== vexp[recv]) begin
                    n_fail++;
                    $display("FAIL b2b_value[%0d]: got %h want %h", recv, float_out, vexp[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv != 12) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 12", recv);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        logic [31:0] got;
        int          lat;
        int          stale = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            fix_in   = {32'(k + 5), 32'h0};
        end
        @(negedge clk);
        in_valid = 1'b0;
        fix_in   = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstm_pre_valid: got %b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || float_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rstm_async_clear: got valid %b data %h want valid 0 data 00000000",
                     out_valid, float_out);
        end
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rstm_stale: got %0d stale outputs want 0", stale);
        end
        convert_single(64'h00000002_00000000, got, lat);
        n_checks++;
        if (got !== 32'h40000000) begin
            n_fail++;
            $display("FAIL rstm_value: got %h want 40000000", got);
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL rstm_latency: got %0d want 4", lat);
        end
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rstm_extra: got %0d extra outputs want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_rounding();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_to_float_pipe.md
Name: fixed_to_float_pipe

Overview:
- Pipelined converter from signed two's-complement fixed-point to IEEE-754 single-precision float.
- Reverse direction of the float-to-fixed adder-tree path: fixed-point accumulator results return to float for downstream consumers and the host interface.
- Valid/ready on both sides; 4-stage pipeline with full backpressure; one conversion per cycle sustained.

Parameters:
- DATA_WIDTH_fix, 64: fixed-point input width, signed two's complement.
- DATA_WIDTH_float, 32: float output width; only 32 is supported.
- FRAC_BITS, 32: number of fractional bits in the fixed-point input. Constraints: FRAC_BITS <= 126 and (DATA_WIDTH_fix - FRAC_BITS) <= 128, so no float overflow or denormal can occur.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- fix_in  input  DATA_WIDTH_fix  fixed-point operand.
- in_valid  input  1  fix_in valid.
- in_ready  output  1  block accepts fix_in this cycle.
- float_out  output  DATA_WIDTH_float  converted result.
- out_valid  output  1  float_out valid.
- out_ready  input  1  downstream accepts float_out.

Behaviour:
- Reset: out_valid=0, float_out=0, all internal stage valids=0. in_ready is high as soon as rst is released; it is combinational from stage state.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv.
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - When adv=0, every stage holds its data and valid; no bubble collapsing is required.
- Latency: 4 cycles from input transfer to out_valid, with no stall. Throughput is 1 per cycle.
- S1: capture sign = fix_in MSB; mag = |fix_in| at DATA_WIDTH_fix bits.
  - Most negative input: mag = 2^(DATA_WIDTH_fix-1) as unsigned; no overflow.
- S2: leading-one position p from a priority encoder on mag; zero flag when mag == 0.
- S3: left-normalize mag so the leading one sits at the MSB. Unbiased exponent e = p - FRAC_BITS; biased exponent = e + 127.
- S4: mantissa = 23 bits below the leading one. Guard bit = next bit; sticky = OR of all remaining lower bits. Round per the optional feature, then pack {sign, exp[7:0], mant[22:0]}.
  - Rounding carry out of the mantissa: mantissa becomes 0 and exponent increments by 1.
- Zero input: output 0x00000000 (+0); no -0 is ever produced.
- Boundary cases:
  - Value exactly representable (fewer than 25 significant bits): guard=sticky=0, exact result.
  - Simultaneous input and output transfer in the same cycle: both take effect; the pipeline shifts by one stage.
  - in_valid=0 while adv=1: a bubble (stage valid=0) enters S1.
  - Reset asserted mid-operation: all in-flight data is discarded immediately, out_valid drops asynchronously, and no stale result appears after release.
  - out_valid must not depend combinationally on out_ready.
  - float_out is stable while out_valid && !out_ready.

Optional Feature:
- Macro: FIX2FLT_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even. Round up when guard && (sticky || mant LSB).
- Undefined: truncate toward zero. Guard and sticky are ignored, and the S4 rounding adder and carry logic are removed.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic conversions, no stall (FRAC_BITS=32):
  - 0x00000001_00000000 (1.0) -> 0x3F800000.
  - 0xFFFFFFFD_00000000 (-3.0) -> 0xC0400000.
  - 0x00000000_80000000 (0.5) -> 0x3F000000.
  - All appear exactly 4 cycles after acceptance.
- Edge values:
  - 0 -> 0x00000000.
  - 0x80000000_00000000 (-2^31) -> 0xCF000000.
  - 0x00000000_00000001 (2^-32) -> 0x2F800000.
- Rounding:
  - 0x01000003_00000000 (2^24+3, tie) -> 0x4B800002 with RNE; 0x4B800001 with truncate.
  - 0x01FFFFFF_00000000 (2^25-1) -> 0x4C000000 with RNE (carry into exponent); 0x4BFFFFFF with truncate.
- Backpressure:
  - Stream 8 back-to-back values 1.0..8.0 with out_ready held low for cycles 5-9.
  - in_ready drops once out_valid && !out_ready.
  - float_out holds stable throughout the stall.
  - All 8 results (0x3F800000 .. 0x41000000) emerge in order with no loss or duplication.
- Reset mid-stream:
  - Assert rst with 3 conversions in flight.
  - out_valid=0 immediately.
  - After release, the first new input 2.0 yields 0x40000000 only, 4 cycles later.
- Random: 10k random fix_in with random in_valid/out_ready duty, checked against a reference model in both macro builds.
